detect_zero_one_run: RTL and testbench
======================================

// Module: detect_zero_one_run
// PURPOSE
// - Parametrised, clocked successor to the 8-bit combinational all-zero/all-one detector.
// - Classifies each valid WIDTH-bit word of an input stream as all-zero, all-one or mixed.
// - Tracks the current run length of consecutive all-zero and all-one words.
// - Raises a hit pulse and a sticky flag when a run reaches a programmable threshold.
// - Sits on a data stream as a link-idle / stuck-bus monitor.
// PARAMETERS
// - WIDTH  8  data word width; >=1. WIDTH=1: 0 is all-zero, 1 is all-one.
// - CNT_W  4  run-counter and threshold width; counters saturate at 2^CNT_W-1.
// PORTS
// - clk         in   1      single clock; all state changes on posedge clk.
// - rst_n       in   1      synchronous, active-low reset.
// - clr         in   1      synchronous clear of counters, flags and FSM.
// - in_valid    in   1      in_data is sampled this cycle.
// - in_data     in   WIDTH  word under test.
// - thresh      in   CNT_W  run length that triggers a hit; 0 disables hits.
// - zero        out  1      last accepted word was all-zero (registered).
// - one         out  1      last accepted word was all-one (registered).
// - zero_run    out  CNT_W  current consecutive all-zero word count.
// - one_run     out  CNT_W  current consecutive all-one word count.
// - zero_hit    out  1      1-cycle pulse when zero_run becomes equal to thresh.
// - one_hit     out  1      1-cycle pulse when one_run becomes equal to thresh.
// - zero_sticky out  1      set by zero_hit; held until clr or reset.
// - one_sticky  out  1      set by one_hit; held until clr or reset.
// BEHAVIOUR
// - Reset: rst_n=0 at a posedge forces all outputs to 0 and FSM to S_MIX.
//   Reset applies mid-run and overrides clr and in_valid.
// - Priority at each edge: rst_n, then clr, then in_valid.
// - clr=1: same effect as reset. A word presented with clr is discarded.
// - Latency: a word accepted at edge N is reflected in every output after edge N.
// - in_valid=0: zero, one, both counters, FSM and sticky flags hold; hits are 0.
// - FSM has 3 states: S_MIX (no word yet or last word mixed), S_ZERO, S_ONE.
//   Transitions are taken on accepted words only:
//     all-zero word -> S_ZERO
//     all-one word  -> S_ONE
//     mixed word    -> S_MIX
// - Counters on an accepted word:
//     all-zero: zero_run <= sat(zero_run+1), one_run <= 0
//     all-one:  one_run  <= sat(one_run+1),  zero_run <= 0
//     mixed:    both counters <= 0
//   A state change always restarts the new run at 1.
// - Saturation: a counter stops at 2^CNT_W-1 and never wraps.
// - Hit: x_hit=1 for exactly one cycle when an accepted word makes x_run go from !=thresh to ==thresh.
//   - thresh=0 never produces a hit.
//   - A saturated counter with thresh = max hits once only.
//   - thresh is sampled at the acceptance edge. Lowering thresh below the current run gives no hit.
//   - Raising thresh above the current run re-arms the hit.
// - zero and one are never both 1. Hit and sticky update at the same edge.
// STRUCTURE
// - Package detect_zero_one_pkg holds:
//   - FSM state encoding: S_MIX=2'd0, S_ZERO=2'd1, S_ONE=2'd2.
//   - Word-class constants.
// - Sub-module run_counter (CNT_W): saturating counter with inc, restart, clear,
//   thresh compare, hit pulse and sticky flag. Instantiated twice, for zero and for one.
// - Top level holds the word classifier (reduction AND/NOR), the FSM and the output registers.
// TESTING (WIDTH=8, CNT_W=4, thresh=3 unless stated)
// - Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=8'hFF -> all outputs 0.
// - Zero run: four valid 8'h00 words
//   -> zero_run 1,2,3,4; zero_hit high only after the 3rd word.
//   -> zero_sticky=1 from then on; one_run=0 throughout.
// - Switch: after the zero run, send 8'hFF then 8'hAA
//   -> after 8'hFF: zero_run=0, one_run=1, one=1.
//   -> after 8'hAA: both counters 0, zero=one=0; zero_sticky still 1.
// - Saturation: thresh=15, twenty 8'h00 words
//   -> zero_run sticks at 15; exactly one zero_hit, on the 15th word.
// - Gaps and clear: 8'h00, in_valid=0 for 3 cycles, 8'h00 -> zero_run 1, held 1, then 2.
//   Then clr=1 with in_valid=1, 8'h00 -> all counters and stickies 0, word not counted.
// - Mid-run reset and thresh=0: reset after a run of 2 -> all 0.
//   Then thresh=0 with five 8'hFF words -> one_run=5, no one_hit, one_sticky stays 0.

Source files
------------

// File: rtl/detect_zero_one_pkg.sv
// Shared encodings for the all-zero / all-one run detector.
// FSM state values and word-class constants used by the classifier.
package detect_zero_one_pkg;

  typedef enum logic [1:0] {
    S_MIX  = 2'd0,
    S_ZERO = 2'd1,
    S_ONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WC_MIX  = 2'd0,
    WC_ZERO = 2'd1,
    WC_ONE  = 2'd2
  } wclass_t;

endpackage

// File: rtl/detect_zero_one_run_counter.sv
// Saturating run counter with threshold hit pulse and sticky flag; 1-cycle latency.
// No backpressure: inc/restart are acted on at the edge they are presented.
module run_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             restart,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] cnt,
  output logic             hit,
  output logic             sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;
  logic             hit_nxt;

  // A hit needs a transition into thresh, so a saturated counter parked on
  // thresh, or a thresh lowered below the run, cannot fire again.
  always_comb begin
    cnt_nxt = cnt;
    hit_nxt = 1'b0;
    if (restart) begin
      cnt_nxt = '0;
    end else if (inc) begin
      if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      hit_nxt = (thresh != '0) && (cnt_nxt == thresh) && (cnt != thresh);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt    <= '0;
      hit    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      hit    <= hit_nxt;
      sticky <= sticky | hit_nxt;
    end
  end

endmodule

// File: rtl/detect_zero_one_run.sv
// Classifies stream words as all-zero/all-one/mixed and tracks run lengths; 1-cycle latency.
// No backpressure: every in_valid word is accepted; in_valid=0 holds all state.
module detect_zero_one_run
  import detect_zero_one_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] thresh,
  output logic             zero,
  output logic             one,
  output logic [CNT_W-1:0] zero_run,
  output logic [CNT_W-1:0] one_run,
  output logic             zero_hit,
  output logic             one_hit,
  output logic             zero_sticky,
  output logic             one_sticky
);

  wclass_t wc;
  state_t  state, state_nxt;

  always_comb begin
    wc = WC_MIX;
    if (~|in_data) begin
      wc = WC_ZERO;
    end else if (&in_data) begin
      wc = WC_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      case (wc)
        WC_ZERO: state_nxt = S_ZERO;
        WC_ONE:  state_nxt = S_ONE;
        default: state_nxt = S_MIX;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= S_MIX;
    end else begin
      state <= state_nxt;
    end
  end

  // zero/one come straight off the state register, so they are exclusive.
  assign zero = (state == S_ZERO);
  assign one  = (state == S_ONE);

  logic zero_inc, one_inc;

  assign zero_inc = in_valid && (wc == WC_ZERO);
  assign one_inc  = in_valid && (wc == WC_ONE);

  run_counter #(.CNT_W(CNT_W)) u_zero_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (zero_inc),
    .restart (in_valid && !zero_inc),
    .thresh  (thresh),
    .cnt     (zero_run),
    .hit     (zero_hit),
    .sticky  (zero_sticky)
  );

  run_counter #(.CNT_W(CNT_W)) u_one_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (one_inc),
    .restart (in_valid && !one_inc),
    .thresh  (thresh),
    .cnt     (one_run),
    .hit     (one_hit),
    .sticky  (one_sticky)
  );

endmodule

// File: tb/tb_detect_zero_one_run.sv
// Directed bench for detect_zero_one_run at WIDTH=8, CNT_W=4.
module tb_detect_zero_one_run;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] thresh;
  logic       zero, one, zero_hit, one_hit, zero_sticky, one_sticky;
  logic [3:0] zero_run, one_run;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  detect_zero_one_run #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .thresh      (thresh),
    .zero        (zero),
    .one         (one),
    .zero_run    (zero_run),
    .one_run     (one_run),
    .zero_hit    (zero_hit),
    .one_hit     (one_hit),
    .zero_sticky (zero_sticky),
    .one_sticky  (one_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic z, input logic o,
                         input logic [3:0] zr, input logic [3:0] orn,
                         input logic zh, input logic oh, input logic zs, input logic os);
    chk({tag, ".zero"},        32'(zero),        32'(z));
    chk({tag, ".one"},         32'(one),         32'(o));
    chk({tag, ".zero_run"},    32'(zero_run),    32'(zr));
    chk({tag, ".one_run"},     32'(one_run),     32'(orn));
    chk({tag, ".zero_hit"},    32'(zero_hit),    32'(zh));
    chk({tag, ".one_hit"},     32'(one_hit),     32'(oh));
    chk({tag, ".zero_sticky"}, 32'(zero_sticky), 32'(zs));
    chk({tag, ".one_sticky"},  32'(one_sticky),  32'(os));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 8'hFF; thresh = 4'd3;

    // reset held two cycles while valid all-one words are offered
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // zero run, thresh=3
    step(1'b1, 8'h00); chk_all("zrun1", 1, 0, 1, 0, 0, 0, 0, 0);
    step(1'b1, 8'h00); chk_all("zrun2", 1, 0, 2, 0, 0, 0, 0, 0);
    step(1'b1, 8'h00); chk_all("zrun3", 1, 0, 3, 0, 1, 0, 1, 0);
    step(1'b1, 8'h00); chk_all("zrun4", 1, 0, 4, 0, 0, 0, 1, 0);

    // switch to all-one, then mixed
    step(1'b1, 8'hFF); chk_all("sw_ff", 0, 1, 0, 1, 0, 0, 1, 0);
    step(1'b1, 8'hAA); chk_all("sw_aa", 0, 0, 0, 0, 0, 0, 1, 0);

    // saturation at 15 with thresh=15
    thresh = 4'd15;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 8'h00);
      chk($sformatf("sat%0d.zero_run", i), 32'(zero_run), (i < 15) ? i : 15);
      chk($sformatf("sat%0d.zero_hit", i), 32'(zero_hit), (i == 15) ? 1 : 0);
    end
    chk("sat.zero_sticky", 32'(zero_sticky), 1);

    // gaps hold state and suppress hits
    thresh = 4'd3;
    step(1'b1, 8'h55); chk_all("gap_mix", 0, 0, 0, 0, 0, 0, 1, 0);
    step(1'b1, 8'h00); chk_all("gap_w1", 1, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF);
      chk_all($sformatf("gap_idle%0d", i), 1, 0, 1, 0, 0, 0, 1, 0);
    end
    step(1'b1, 8'h00); chk_all("gap_w2", 1, 0, 2, 0, 0, 0, 1, 0);

    // clr wins over a valid word
    clr = 1'b1;
    step(1'b1, 8'h00); chk_all("clr", 0, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b0;

    // mid-run reset
    step(1'b1, 8'h00);
    step(1'b1, 8'h00); chk_all("mr_run2", 1, 0, 2, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(1'b1, 8'h00); chk_all("mr_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // thresh=0 disables hits
    thresh = 4'd0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'hFF);
      chk_all($sformatf("t0_%0d", i), 0, 1, 0, 4'(i), 0, 0, 0, 0);
    end

    // lowering thresh below the run gives no hit; raising it re-arms
    thresh = 4'd2;
    step(1'b1, 8'hFF); chk_all("lower", 0, 1, 0, 6, 0, 0, 0, 0);
    thresh = 4'd8;
    step(1'b1, 8'hFF); chk_all("raise7", 0, 1, 0, 7, 0, 0, 0, 0);
    step(1'b1, 8'hFF); chk_all("raise8", 0, 1, 0, 8, 0, 1, 0, 1);
    step(1'b1, 8'hFF); chk_all("raise9", 0, 1, 0, 9, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
